sprite_compositor: RTL
======================

# sprite_compositor

Per-pixel compositor sitting directly downstream of the two player sprite ROM readers and the background source, upstream of the VGA DAC pins. It delays the timing generator's sync/active strobes to line up with the sprite read latency and resolves sprite-vs-sprite-vs-background priority. It applies frame-synchronous priority swap and hit-blink effects and expands RGB332 pixels to 8-bit-per-channel DAC outputs.

## Interface
- SYNC_DELAY, 2: cycles between the pixel coordinate leaving the timing generator and the sprite `visible_flag`/`data` arriving here (range 1..4).
- BLINK_PERIOD, 8: frames per blink half-period (range 1..255).
- clk  in  1  pixel clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hsync_in  in  1  active-low hsync, same cycle as the pixel coordinates.
- vsync_in  in  1  active-low vsync, same cycle as the pixel coordinates.
- active_in  in  1  high inside the 640x480 visible region, same cycle as the coordinates.
- p1_visible  in  1  player-1 sprite opaque at this pixel, SYNC_DELAY cycles after the coordinates.
- p1_data  in  8  player-1 pixel, RGB332 format.
- p2_visible, p2_data  in  1, 8  player-2 equivalents.
- bg_data  in  8  background RGB332, aligned with the sprite inputs.
- p2_on_top  in  1  priority request; 1 means player 2 is drawn over player 1.
- p1_blink, p2_blink  in  1  blink-enable requests (hit/invincibility).
- vga_r, vga_g, vga_b  out  8 each  DAC colour.
- vga_hsync, vga_vsync  out  1  active-low syncs, aligned with the colour outputs.
- vga_blank_n  out  1  high when the colour is valid.
- frame_start  out  1  one-cycle pulse at each frame boundary.

## Operation
- **Sync delay line.** SYNC_DELAY register stages each for hsync, vsync and active.
  - Reset values: hsync = 1, vsync = 1, active = 0.
  - Delayed values are named hs_d, vs_d, act_d.
- **Frame boundary.** A frame boundary is the cycle in which vs_d is 0 and the previous vs_d was 1. The edge detector's previous-value register resets to 1.
- **At each frame boundary:**
  - Latch p2_on_top, p1_blink and p2_blink into shadow registers. All shadows reset to 0.
  - Advance frame_cnt, which counts 0..BLINK_PERIOD-1 (width 8 bits).
  - When frame_cnt wraps to 0, toggle blink_phase (reset 0).
- **Shadow usage.** Mid-frame changes on the request inputs have no effect. Only the shadows are used for compositing.
- **Effective visibility.** e1 = p1_visible & ~(p1_blink_sh & blink_phase). e2 is formed the same way from the player-2 inputs.
- **Pixel selection, in order:**
  - If act_d = 0, the pixel is 8'h00.
  - Otherwise the top sprite is used if its e is set. The top sprite is p2 when p2_on_top_sh = 1, else p1.
  - Otherwise the other sprite is used if its e is set.
  - Otherwise bg_data is used.
- **Colour expansion.** The pixel format is {r[2:0], g[2:0], b[1:0]}.
  - R = {r, r, r[2:1]}
  - G = {g, g, g[2:1]}
  - B = {b, b, b, b}
  - This gives full-scale 8'hFF for all-ones inputs and 8'h00 for zero.
- **Output register.** All outputs are registered: colour, hs_d, vs_d, act_d (driving vga_blank_n) and the boundary pulse (driving frame_start).
- **Reset values of outputs:**
  - vga_r, vga_g, vga_b = 0
  - vga_hsync = 1, vga_vsync = 1
  - vga_blank_n = 0, frame_start = 0
- **Reset mid-frame.** Everything returns to its reset value and output stays blanked. The first frame_start occurs at the next vsync falling edge seen at the end of the delay line. Blink restarts with phase 0 and counter 0.

## Timing
- Colour outputs reflect sprite/bg inputs 1 cycle after those inputs.
- Sync/blank outputs reflect the *_in signals SYNC_DELAY+1 cycles after them. Syncs and colour for the same pixel therefore appear in the same cycle.
- frame_start is coincident with the first output cycle in which vga_vsync = 0.
- The shadow registers update in the boundary cycle. They first affect the pixel that reaches the selection logic in the next cycle, which is always blanked because vsync lies in the blanking interval.
- Blink toggles every BLINK_PERIOD frame boundaries. With the default, the sprite is hidden for 8 frames and shown for 8 frames.
- No stalls and no handshake: one pixel in, one pixel out, every cycle.

## Test plan
- **Reset values.** Hold rst_n = 0 with random inputs -> outputs 0/1/1/0/0. Release and drive vsync_in low at cycle 10 -> frame_start = 1 and vga_vsync = 0 exactly at cycle 13 (SYNC_DELAY = 2).
- **Background only.** act = 1, p1_visible = p2_visible = 0, bg = 8'hE3 -> one cycle later R = 8'hFF, G = 8'h00, B = 8'hFF.
- **Priority.** Both visible, p1_data = 8'h1C, p2_data = 8'h03, p2_on_top = 0 -> output G = 8'hFF, R = B = 0. Set p2_on_top = 1 mid-frame -> unchanged until after the next frame_start, then B = 8'hFF only.
- **Blanking.** act_in = 0 with both sprites visible -> colour 0 and vga_blank_n = 0.
- **Blink.** Set p1_blink = 1 with p1 on top over an opaque bg of 8'h1C:
  - Frames 1-8 show p1 and frames 9-16 show bg (blink_phase = 1), then the pattern repeats.
  - p2_blink = 0 -> p2 is unaffected.
- **Reset mid-frame.** Assert rst_n during active video with blink_phase = 1 -> outputs blank immediately (asynchronously). After release, blink_phase = 0 and shadows = 0: p1 is on top with no blink.

Source files
------------

// File: rtl/sprite_compositor.sv
// sprite_compositor: aligns syncs to sprite read latency, resolves sprite/bg priority with
// frame-synchronous swap and blink, and expands RGB332 to 8-bit-per-channel DAC outputs.
module sprite_compositor #(
  parameter int SYNC_DELAY = 2,
  parameter int BLINK_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       active_in,
  input  logic       p1_visible,
  input  logic [7:0] p1_data,
  input  logic       p2_visible,
  input  logic [7:0] p2_data,
  input  logic [7:0] bg_data,
  input  logic       p2_on_top,
  input  logic       p1_blink,
  input  logic       p2_blink,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_blank_n,
  output logic       frame_start
);
  logic [SYNC_DELAY-1:0] hs_sr, vs_sr, act_sr;
  logic hs_d, vs_d, act_d, vs_prev, boundary, wrap;
  logic top_sh, b1_sh, b2_sh, blink_phase, e1, e2;
  logic [7:0] frame_cnt, pix;
  assign hs_d = hs_sr[SYNC_DELAY-1];
  assign vs_d = vs_sr[SYNC_DELAY-1];
  assign act_d = act_sr[SYNC_DELAY-1];
  assign boundary = vs_prev & ~vs_d;
  assign wrap = frame_cnt == 8'(BLINK_PERIOD - 1);
  assign e1 = p1_visible & ~(b1_sh & blink_phase);
  assign e2 = p2_visible & ~(b2_sh & blink_phase);
  // Top sprite wins, then the other sprite, then background; outside active video force black.
  always_comb
    pix = !act_d ? 8'h00 :
          top_sh ? (e2 ? p2_data : e1 ? p1_data : bg_data) :
                   (e1 ? p1_data : e2 ? p2_data : bg_data);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hs_sr <= '1;
      vs_sr <= '1;
      act_sr <= '0;
      vs_prev <= 1'b1;
      top_sh <= 1'b0;
      b1_sh <= 1'b0;
      b2_sh <= 1'b0;
      frame_cnt <= 8'd0;
      blink_phase <= 1'b0;
      vga_r <= 8'h00;
      vga_g <= 8'h00;
      vga_b <= 8'h00;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs_sr <= (hs_sr << 1) | SYNC_DELAY'(hsync_in);
      vs_sr <= (vs_sr << 1) | SYNC_DELAY'(vsync_in);
      act_sr <= (act_sr << 1) | SYNC_DELAY'(active_in);
      vs_prev <= vs_d;
      if (boundary) begin
        top_sh <= p2_on_top;
        b1_sh <= p1_blink;
        b2_sh <= p2_blink;
        frame_cnt <= wrap ? 8'd0 : frame_cnt + 8'd1;
        if (wrap) blink_phase <= ~blink_phase;
      end
      vga_r <= {pix[7:5], pix[7:5], pix[7:6]};
      vga_g <= {pix[4:2], pix[4:2], pix[4:3]};
      vga_b <= {4{pix[1:0]}};
      vga_hsync <= hs_d;
      vga_vsync <= vs_d;
      vga_blank_n <= act_d;
      frame_start <= boundary;
    end
endmodule
